// File: rtl/packet_slip_framer_pkg.sv
// Shared SLIP definitions: byte codes and the framer state encoding.
package packet_slip_framer_pkg;

  localparam logic [7:0] SLIP_END     = 8'hC0;
  localparam logic [7:0] SLIP_ESC     = 8'hDB;
  localparam logic [7:0] SLIP_ESC_END = 8'hDC;
  localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

  typedef enum logic [2:0] {
    StIdle,
    StData,
    StEsc2,
    StSum,
    StSumEsc2,
    StClose
  } slip_state_e;

endpackage

// File: rtl/slip_escape.sv
// Combinational SLIP escape lookup: flags bytes that must be escaped and
// supplies the code byte that follows ESC on the wire.
module slip_escape
  import packet_slip_framer_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic       needs_esc_o,
  output logic [7:0] code_o
);

  // Only END and ESC collide with framing; everything else passes through.
  always_comb begin
    needs_esc_o = 1'b0;
    code_o      = 8'h00;
    if (byte_i == SLIP_END) begin
      needs_esc_o = 1'b1;
      code_o      = SLIP_ESC_END;
    end else if (byte_i == SLIP_ESC) begin
      needs_esc_o = 1'b1;
      code_o      = SLIP_ESC_ESC;
    end
  end

endmodule

// File: rtl/packet_slip_framer.sv
// Pops packet words from a first-word-fall-through FIFO and emits a SLIP
// byte stream: optional leading END, escaped payload, optional escaped
// two's-complement checksum, closing END flagged with out_last.
module packet_slip_framer
  import packet_slip_framer_pkg::*;
#(
  parameter bit LEAD_END = 1'b1,
  parameter bit CHECKSUM = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_nempty,
  input  logic [7:0] in_data,
  input  logic       in_end,
  output logic       in_pop,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready
);

  slip_state_e state_q, state_d;
  slip_state_e after_data;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_last_q, out_last_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  pend_q, pend_d;
  logic        end_pend_q, end_pend_d;
  logic        load_ok;
  logic [7:0]  cksum;
  logic [7:0]  esc_byte;
  logic [7:0]  esc_code;
  logic        esc_need;

  // Output register may take a new byte when empty or being drained.
  assign load_ok    = !out_valid_q || out_ready;
  assign cksum      = 8'h00 - sum_q;
  assign after_data = CHECKSUM ? StSum : StClose;
  // The escaper is shared: checksum only goes through it in StSum.
  assign esc_byte   = (state_q == StSum) ? cksum : in_data;

  slip_escape u_escape (
    .byte_i      (esc_byte),
    .needs_esc_o (esc_need),
    .code_o      (esc_code)
  );

  // Next-state, output-register load and FIFO pop decode.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    sum_d       = sum_q;
    pend_d      = pend_q;
    end_pend_d  = end_pend_q;
    in_pop      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (in_nempty && load_ok) begin
          sum_d = 8'h00;
          if (LEAD_END) begin
            out_valid_d = 1'b1;
            out_data_d  = SLIP_END;
            out_last_d  = 1'b0;
          end
          state_d = StData;
        end
      end
      StData: begin
        if (in_nempty && load_ok) begin
          in_pop      = 1'b1;
          sum_d       = sum_q + in_data;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          if (esc_need) begin
            out_data_d = SLIP_ESC;
            pend_d     = esc_code;
            end_pend_d = in_end;
            state_d    = StEsc2;
          end else begin
            out_data_d = in_data;
            if (in_end) state_d = after_data;
          end
        end
      end
      StEsc2: begin
        if (load_ok) begin
          out_valid_d = 1'b1;
          out_data_d  = pend_q;
          out_last_d  = 1'b0;
          state_d     = end_pend_q ? after_data : StData;
        end
      end
      StSum: begin
        if (load_ok) begin
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          if (esc_need) begin
            out_data_d = SLIP_ESC;
            pend_d     = esc_code;
            state_d    = StSumEsc2;
          end else begin
            out_data_d = cksum;
            state_d    = StClose;
          end
        end
      end
      StSumEsc2: begin
        if (load_ok) begin
          out_valid_d = 1'b1;
          out_data_d  = pend_q;
          out_last_d  = 1'b0;
          state_d     = StClose;
        end
      end
      StClose: begin
        if (load_ok) begin
          out_valid_d = 1'b1;
          out_data_d  = SLIP_END;
          out_last_d  = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, output register, running sum and pending escape code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
      sum_q       <= 8'h00;
      pend_q      <= 8'h00;
      end_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      sum_q       <= sum_d;
      pend_q      <= pend_d;
      end_pend_q  <= end_pend_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_packet_slip_framer.sv
// Bench for packet_slip_framer: three instances (full framing, no leading
// END, no checksum) each fed by a modelled FWFT FIFO. Directed frames are
// compared against hand-derived byte sequences; a random run decodes the
// captured SLIP stream and compares payloads and checksums to what was sent.
module tb_packet_slip_framer;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] in_nempty, in_end, in_pop, out_valid, out_last, out_ready;
  logic [7:0] in_data  [3];
  logic [7:0] out_data [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    packet_slip_framer #(
      .LEAD_END (g != 1),
      .CHECKSUM (g != 2)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_nempty (in_nempty[g]),
      .in_data   (in_data[g]),
      .in_end    (in_end[g]),
      .in_pop    (in_pop[g]),
      .out_valid (out_valid[g]),
      .out_data  (out_data[g]),
      .out_last  (out_last[g]),
      .out_ready (out_ready[g])
    );
  end

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // FIFO model: word memory with free-running pointers.
  logic [8:0]  mem [3][4096];
  int unsigned wr [3];
  int unsigned rd [3];
  logic [2:0]  flush;
  logic        rnd_en, rdy_fix, rdy_rand, hold_rand;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      in_nempty[i] = (rd[i] != wr[i]) && !(i == 0 && rnd_en && hold_rand);
      in_data[i]   = mem[i][rd[i] % 4096][7:0];
      in_end[i]    = mem[i][rd[i] % 4096][8];
    end
  end

  assign out_ready = {2'b11, rnd_en ? rdy_rand : rdy_fix};

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (flush[i]) rd[i] <= wr[i];
      else if (in_pop[i]) rd[i] <= rd[i] + 1;
    end
  end

  always begin
    @(posedge clk);
    #1;
    rdy_rand  = 1'($urandom_range(0, 1));
    hold_rand = ($urandom_range(0, 3) == 0);
  end

  task automatic push(input int i, input logic [7:0] b, input logic e);
    mem[i][wr[i] % 4096] = {e, b};
    wr[i]++;
  endtask

  // Output monitor: captures accepted bytes and checks stall behaviour on dut 0.
  logic [8:0] cap     [3][4096];
  int         cap_cyc [3][4096];
  int         ncap [3];
  int         nlast [3];
  int         cyc = 0;
  logic       stall_q = 1'b0;
  logic [8:0] stall_word;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          cap[i][ncap[i]]     = {out_last[i], out_data[i]};
          cap_cyc[i][ncap[i]] = cyc;
          ncap[i]++;
          if (out_last[i]) nlast[i]++;
        end
      end
      if (stall_q) begin
        chk("stall_hold", {23'd0, out_last[0], out_data[0]}, {23'd0, stall_word});
        chk("stall_valid", out_valid[0], 1);
      end
      if (out_valid[0] && !out_ready[0]) begin
        chk("stall_nopop", in_pop[0], 0);
        stall_q    = 1'b1;
        stall_word = {out_last[0], out_data[0]};
      end else begin
        stall_q = 1'b0;
      end
    end
  end

  task automatic wait_cap(input int i, input int base, input int n);
    for (int t = 0; t < 400 && ncap[i] - base < n; t++) @(posedge clk);
    #1;
  endtask

  task automatic cmp_cap(input int i, input int base, input string tag, input bq_t exp);
    chk({tag, "_len"}, ncap[i] - base, exp.size());
    for (int k = 0; k < exp.size(); k++) begin
      if (base + k < ncap[i]) begin
        chk($sformatf("%s_b%0d", tag, k), cap[i][base + k][7:0], exp[k]);
        chk($sformatf("%s_l%0d", tag, k), cap[i][base + k][8], k == exp.size() - 1);
      end
    end
  endtask

  task automatic run_pkt(input int i, input string tag, input bq_t pkt, input bq_t exp,
                         output int base, output int t0);
    @(posedge clk);
    #1;
    base = ncap[i];
    t0   = cyc;
    for (int k = 0; k < pkt.size(); k++) push(i, pkt[k], k == pkt.size() - 1);
    wait_cap(i, base, exp.size());
    repeat (3) @(posedge clk);
    #1;
    cmp_cap(i, base, tag, exp);
  endtask

  logic [7:0] rp_byte [1024];
  int         rp_len  [100];

  initial begin
    bq_t        p, e, acc;
    int         b, t0, off, pk, n;
    logic [7:0] d, s;
    logic       esc;

    rst = 1'b1; rnd_en = 1'b0; rdy_fix = 1'b1; flush = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", out_valid[0], 0);
    chk("rst_data", out_data[0], 8'h00);
    chk("rst_last", out_last[0], 0);
    chk("rst_pop", in_pop[0], 0);
    chk("rst_valid_v", {out_valid[2], out_valid[1]}, 0);

    p = '{8'h01, 8'h02}; e = '{8'hC0, 8'h01, 8'h02, 8'hFD, 8'hC0};
    run_pkt(0, "basic", p, e, b, t0);
    chk("basic_latency", cap_cyc[0][b] - t0, 2);
    chk("basic_b2b", cap_cyc[0][b + 4] - cap_cyc[0][b], 4);

    p = '{8'hC0}; e = '{8'hC0, 8'hDB, 8'hDC, 8'h40, 8'hC0};
    run_pkt(0, "esc_end", p, e, b, t0);
    p = '{8'hDB}; e = '{8'hC0, 8'hDB, 8'hDD, 8'h25, 8'hC0};
    run_pkt(0, "esc_esc", p, e, b, t0);
    p = '{8'h40}; e = '{8'hC0, 8'h40, 8'hDB, 8'hDC, 8'hC0};
    run_pkt(0, "sum_esc", p, e, b, t0);

    p = '{8'h01, 8'h02}; e = '{8'h01, 8'h02, 8'hFD, 8'hC0};
    run_pkt(1, "no_lead", p, e, b, t0);
    p = '{8'h01, 8'h02}; e = '{8'hC0, 8'h01, 8'h02, 8'hC0};
    run_pkt(2, "no_sum", p, e, b, t0);

    // FIFO runs dry after two of four bytes.
    @(posedge clk);
    #1;
    b = ncap[0];
    push(0, 8'h11, 1'b0);
    push(0, 8'h22, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("uf_valid", out_valid[0], 0);
    chk("uf_cnt", ncap[0] - b, 3);
    @(posedge clk);
    #1;
    push(0, 8'h33, 1'b0);
    push(0, 8'h44, 1'b1);
    wait_cap(0, b, 7);
    repeat (3) @(posedge clk);
    #1;
    e = '{8'hC0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h56, 8'hC0};
    cmp_cap(0, b, "uf", e);

    // Reset in the middle of a frame.
    @(posedge clk);
    #1;
    b = ncap[0];
    push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b0); push(0, 8'h03, 1'b0); push(0, 8'h04, 1'b1);
    wait_cap(0, b, 3);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid[0], 0);
    chk("mid_rst_data", out_data[0], 8'h00);
    chk("mid_rst_last", out_last[0], 0);
    chk("mid_rst_pop", in_pop[0], 0);
    flush[0] = 1'b1;
    @(posedge clk);
    #1;
    flush[0] = 1'b0;
    rst = 1'b0;
    p = '{8'h05}; e = '{8'hC0, 8'h05, 8'hFB, 8'hC0};
    run_pkt(0, "post_rst", p, e, b, t0);

    // Random packets under random backpressure and FIFO gaps.
    rnd_en = 1'b1;
    @(posedge clk);
    #1;
    b   = ncap[0];
    n   = nlast[0];
    off = 0;
    for (int q = 0; q < 100; q++) begin
      rp_len[q] = $urandom_range(1, 8);
      for (int j = 0; j < rp_len[q]; j++) begin
        case ($urandom_range(0, 3))
          0:       d = 8'hC0;
          1:       d = 8'hDB;
          default: d = 8'($urandom_range(0, 255));
        endcase
        rp_byte[off + j] = d;
        push(0, d, j == rp_len[q] - 1);
      end
      off += rp_len[q];
    end
    for (int t = 0; t < 20000 && nlast[0] - n < 100; t++) @(posedge clk);
    #1;
    rnd_en = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    off = 0; pk = 0; esc = 1'b0; acc.delete();
    for (int k = b; k < ncap[0]; k++) begin
      d = cap[0][k][7:0];
      if (d == 8'hC0) begin
        if (cap[0][k][8]) begin
          s = 8'h00;
          foreach (acc[j]) s = s + acc[j];
          chk("rnd_sum", s, 8'h00);
          if (pk < 100) begin
            chk("rnd_len", acc.size() - 1, rp_len[pk]);
            if (acc.size() - 1 == rp_len[pk])
              for (int j = 0; j < rp_len[pk]; j++) chk("rnd_byte", acc[j], rp_byte[off + j]);
            off += rp_len[pk];
          end
          pk++;
          acc.delete();
        end else begin
          chk("rnd_lead_empty", acc.size(), 0);
        end
      end else begin
        chk("rnd_last_flag", cap[0][k][8], 0);
        if (esc) begin
          chk("rnd_esc_code", (d == 8'hDC) || (d == 8'hDD), 1);
          acc.push_back((d == 8'hDC) ? 8'hC0 : 8'hDB);
          esc = 1'b0;
        end else if (d == 8'hDB) begin
          esc = 1'b1;
        end else begin
          acc.push_back(d);
        end
      end
    end
    chk("rnd_frames", pk, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
